collection_drainer: RTL and testbench

- Read-side sequencer for the collection module.
- On a start pulse it sweeps every collector address once, driving the module's read address. Each read also wipes that entry.
- It realigns the returned summed-coefficient data and coefficient count after the fixed read latency, and streams one result per address over a valid/ready interface.
- It keeps running totals for the whole sweep and pulses done when the last result has been accepted downstream.

---
 rtl/collection_drainer_pkg.sv | 20 ++
 rtl/drainer_fifo.sv | 55 +++++
 rtl/collection_drainer.sv | 180 ++++++++++++++++++
 tb/tb_collection_drainer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/collection_drainer_pkg.sv
// Shared widths, FSM encoding and helpers for the collection drainer.
package collection_drainer_pkg;

  localparam int DEF_ADDR_WIDTH   = 12;
  localparam int DEF_READ_LATENCY = 5;
  localparam int SUM_W            = 38;
  localparam int CNT_W            = 3;
  localparam int TOTAL_W          = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_FLUSH
  } drain_state_t;

  function automatic logic [TOTAL_W-1:0] zext_sum(input logic [SUM_W-1:0] s);
    return {{(TOTAL_W-SUM_W){1'b0}}, s};
  endfunction

endpackage

// File: rtl/drainer_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count; DEPTH must be a power of two.
module drainer_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is pure data; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/collection_drainer.sv
// Sweeps every collector address once, realigns the returned data and streams
// one result per address downstream while accumulating sweep totals.
module collection_drainer
  import collection_drainer_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int READ_LATENCY = DEF_READ_LATENCY,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH-1:0]   readAddr,
  input  logic [SUM_W-1:0]        summedDataIn,
  input  logic [CNT_W-1:0]        pcoeffCountIn,
  output logic                    outValid,
  input  logic                    outReady,
  output logic [ADDR_WIDTH-1:0]   outAddr,
  output logic [SUM_W-1:0]        outSum,
  output logic [CNT_W-1:0]        outCount,
  output logic [TOTAL_W-1:0]      totalSum,
  output logic [ADDR_WIDTH+2:0]   totalCount
);

  localparam int ENTRY_W = ADDR_WIDTH + SUM_W + CNT_W;
  localparam int FCNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int INFL_W  = $clog2(READ_LATENCY + 1);
  localparam int TCNT_W  = ADDR_WIDTH + CNT_W;

  drain_state_t              state_q, state_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [ADDR_WIDTH:0]       issue_cnt_q, issue_cnt_d;
  logic [ADDR_WIDTH-1:0]     last_addr_q, last_addr_d;
  logic [READ_LATENCY-1:0]   sr_vld_q, sr_vld_d;
  logic [ADDR_WIDTH-1:0]     sr_addr_q [READ_LATENCY];
  logic [ADDR_WIDTH-1:0]     sr_addr_d [READ_LATENCY];
  logic [INFL_W-1:0]         inflight_q, inflight_d;
  logic [TOTAL_W-1:0]        total_sum_q, total_sum_d;
  logic [TCNT_W-1:0]         total_count_q, total_count_d;

  logic                      credit_ok;
  logic                      issue;
  logic                      push;
  logic                      pop;
  logic                      clr_totals;
  logic [ENTRY_W-1:0]        push_data;
  logic [ENTRY_W-1:0]        head_data;
  logic [FCNT_W-1:0]         fifo_count;
  logic [ADDR_WIDTH-1:0]     read_addr;

  // Credit uses only registered counts, so a same-cycle pop never widens it.
  always_comb begin
    credit_ok = (int'(fifo_count) + int'(inflight_q) + 1) <= FIFO_DEPTH;
    issue     = (state_q == ST_ISSUE) && credit_ok;
    read_addr = issue ? issue_cnt_q[ADDR_WIDTH-1:0] : last_addr_q;
    last_addr_d = read_addr;
  end

  always_comb begin
    sr_vld_d[0]  = issue;
    sr_addr_d[0] = issue_cnt_q[ADDR_WIDTH-1:0];
    for (int i = 1; i < READ_LATENCY; i++) begin
      sr_vld_d[i]  = sr_vld_q[i-1];
      sr_addr_d[i] = sr_addr_q[i-1];
    end
  end

  assign push      = sr_vld_q[READ_LATENCY-1];
  assign push_data = {sr_addr_q[READ_LATENCY-1], summedDataIn, pcoeffCountIn};
  assign pop       = outValid & outReady;

  always_comb begin
    case ({issue, push})
      2'b10:   inflight_d = inflight_q + INFL_W'(1);
      2'b01:   inflight_d = inflight_q - INFL_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    issue_cnt_d = issue_cnt_q;
    clr_totals  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A start coinciding with the done pulse belongs to the old sweep.
        if (start && !done_q) begin
          state_d     = ST_ISSUE;
          busy_d      = 1'b1;
          issue_cnt_d = '0;
          clr_totals  = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (issue) begin
          issue_cnt_d = issue_cnt_q + (ADDR_WIDTH+1)'(1);
          if (issue_cnt_d[ADDR_WIDTH]) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (pop && (fifo_count == FCNT_W'(1)) && (inflight_q == '0)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    total_sum_d   = total_sum_q;
    total_count_d = total_count_q;
    if (clr_totals) begin
      total_sum_d   = '0;
      total_count_d = '0;
    end else if (pop) begin
      total_sum_d   = total_sum_q + zext_sum(outSum);
      total_count_d = total_count_q + TCNT_W'(outCount);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      issue_cnt_q   <= '0;
      last_addr_q   <= '0;
      sr_vld_q      <= '0;
      inflight_q    <= '0;
      total_sum_q   <= '0;
      total_count_q <= '0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      issue_cnt_q   <= issue_cnt_d;
      last_addr_q   <= last_addr_d;
      sr_vld_q      <= sr_vld_d;
      inflight_q    <= inflight_d;
      total_sum_q   <= total_sum_d;
      total_count_q <= total_count_d;
    end
  end

  always_ff @(posedge clk) begin
    sr_addr_q <= sr_addr_d;
  end

  drainer_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_data),
    .count     (fifo_count)
  );

  assign outValid                     = (fifo_count != '0);
  assign {outAddr, outSum, outCount}  = head_data;
  assign readAddr                     = read_addr;
  assign busy                         = busy_q;
  assign done                         = done_q;
  assign totalSum                     = total_sum_q;
  assign totalCount                   = total_count_q;

endmodule

// File: tb/tb_collection_drainer.sv
// Bench for collection_drainer: a collection-memory stand-in with read-wipe and
// fixed latency, and an address-ordered reference image of the expected results.
module tb_collection_drainer;
  import collection_drainer_pkg::*;

  localparam int AW = 12;
  localparam int RL = 5;
  localparam int FD = 16;
  localparam int N  = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, start, outReady;
  logic              busy, done, outValid;
  logic [AW-1:0]     readAddr, outAddr;
  logic [SUM_W-1:0]  summedDataIn, outSum;
  logic [CNT_W-1:0]  pcoeffCountIn, outCount;
  logic [TOTAL_W-1:0] totalSum;
  logic [AW+2:0]     totalCount;

  collection_drainer #(
    .ADDR_WIDTH   (AW),
    .READ_LATENCY (RL),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .readAddr      (readAddr),
    .summedDataIn  (summedDataIn),
    .pcoeffCountIn (pcoeffCountIn),
    .outValid      (outValid),
    .outReady      (outReady),
    .outAddr       (outAddr),
    .outSum        (outSum),
    .outCount      (outCount),
    .totalSum      (totalSum),
    .totalCount    (totalCount)
  );

  // Collection-module stand-in: every read while busy wipes the entry.
  logic [SUM_W-1:0] mem_sum [N];
  logic [CNT_W-1:0] mem_cnt [N];
  logic [SUM_W-1:0] pipe_sum [RL];
  logic [CNT_W-1:0] pipe_cnt [RL];
  logic             clr, ld_en;
  logic [AW-1:0]    ld_addr;
  logic [SUM_W-1:0] ld_sum;
  logic [CNT_W-1:0] ld_cnt;

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < N; i++) begin
        mem_sum[i] <= '0;
        mem_cnt[i] <= '0;
      end
    end else if (ld_en) begin
      mem_sum[ld_addr] <= ld_sum;
      mem_cnt[ld_addr] <= ld_cnt;
    end else if (busy) begin
      mem_sum[readAddr] <= '0;
      mem_cnt[readAddr] <= '0;
    end
    pipe_sum[0] <= mem_sum[readAddr];
    pipe_cnt[0] <= mem_cnt[readAddr];
    for (int i = 1; i < RL; i++) begin
      pipe_sum[i] <= pipe_sum[i-1];
      pipe_cnt[i] <= pipe_cnt[i-1];
    end
  end

  assign summedDataIn  = pipe_sum[RL-1];
  assign pcoeffCountIn = pipe_cnt[RL-1];

  // Reference image: result i of a sweep is address i with these contents.
  logic [SUM_W-1:0] want_sum [N];
  logic [CNT_W-1:0] want_cnt [N];

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
    n_chk++;
    assert (obs === req) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, req);
  endtask

  task automatic clear_all();
    clr = 1'b1;
    for (int i = 0; i < N; i++) begin
      want_sum[i] = '0;
      want_cnt[i] = '0;
    end
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic load(input int a, input logic [SUM_W-1:0] s, input logic [CNT_W-1:0] c);
    ld_en   = 1'b1;
    ld_addr = AW'(a);
    ld_sum  = s;
    ld_cnt  = c;
    want_sum[a] = s;
    want_cnt[a] = c;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Runs one sweep; pct = outReady probability, hold = cycles of outReady=0,
  // mid_start = cycle of a stray start (also retried on done), rst_at = abort cycle.
  task automatic sweep(input string name, input int pct, input int hold,
                       input int mid_start, input int rst_at);
    int          idx;
    int          first_v;
    bit          fin;
    bit          aborted;
    logic [63:0] acc_s;
    logic [63:0] acc_c;
    idx = 0; first_v = -1; fin = 1'b0; aborted = 1'b0; acc_s = '0; acc_c = '0;
    start    = 1'b1;
    outReady = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk({name, "_busy_at_start"}, 64'(busy), 64'd1);
    for (int k = 0; k < 60000; k++) begin
      if (rst_at >= 0 && k == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk({name, "_rst_outValid"}, 64'(outValid), 64'd0);
        chk({name, "_rst_busy"}, 64'(busy), 64'd0);
        chk({name, "_rst_done"}, 64'(done), 64'd0);
        chk({name, "_rst_totalSum"}, totalSum, 64'd0);
        chk({name, "_rst_totalCount"}, 64'(totalCount), 64'd0);
        chk({name, "_rst_readAddr"}, 64'(readAddr), 64'd0);
        fin = 1'b1;
        aborted = 1'b1;
        break;
      end
      if (hold > 0 && k == hold) begin
        chk({name, "_park_readAddr"}, 64'(readAddr), 64'(FD - 1));
        chk({name, "_unread_entry"}, 64'(mem_cnt[FD]), 64'(want_cnt[FD]));
        chk({name, "_held_head"}, 64'(outAddr), 64'd0);
      end
      start    = (k == mid_start);
      outReady = (k >= hold) && ($urandom_range(99) < pct);
      if (outValid && first_v < 0) begin
        first_v = k;
        if (pct == 100 && hold == 0) chk({name, "_first_latency"}, 64'(k), 64'(RL + 1));
      end
      if (outValid) begin
        chk({name, "_outAddr"}, 64'(outAddr), 64'(idx));
        chk({name, "_outSum"}, 64'(outSum), 64'(want_sum[idx % N]));
        chk({name, "_outCount"}, 64'(outCount), 64'(want_cnt[idx % N]));
        if (outReady) begin
          chk({name, "_run_totalSum"}, totalSum, acc_s);
          chk({name, "_run_totalCount"}, 64'(totalCount), acc_c);
          acc_s += 64'(want_sum[idx % N]);
          acc_c += 64'(want_cnt[idx % N]);
          idx++;
        end
      end
      if (done) begin
        chk({name, "_done_after_all"}, 64'(idx), 64'(N));
        chk({name, "_busy_with_done"}, 64'(busy), 64'd0);
        chk({name, "_final_totalSum"}, totalSum, acc_s);
        chk({name, "_final_totalCount"}, 64'(totalCount), acc_c);
        start = (mid_start >= 0);
        fin = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({name, "_finished"}, 64'(fin), 64'd1);
    if (!aborted) begin
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        start = 1'b0;
        chk({name, "_post_busy"}, 64'(busy), 64'd0);
        chk({name, "_post_done"}, 64'(done), 64'd0);
        chk({name, "_post_outValid"}, 64'(outValid), 64'd0);
      end
    end
    outReady = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; outReady = 1'b0;
    clr = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_sum = '0; ld_cnt = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_outValid", 64'(outValid), 64'd0);
    chk("reset_readAddr", 64'(readAddr), 64'd0);
    chk("reset_totalSum", totalSum, 64'd0);
    chk("reset_totalCount", 64'(totalCount), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    clear_all();
    load(0, 38'd5, 3'd1);
    load(1, 38'd7, 3'd2);
    load(2, 38'd9, 3'd3);
    sweep("basic", 100, 0, -1, -1);
    chk("basic_totalSum", totalSum, 64'd21);
    chk("basic_totalCount", 64'(totalCount), 64'd6);

    clear_all();
    load(15, 38'd11, 3'd1);
    load(16, 38'd22, 3'd2);
    load(4095, 38'd33, 3'd3);
    sweep("hold", 100, 100, -1, -1);

    clear_all();
    for (int i = 0; i < 24; i++)
      load(int'($urandom_range(N - 1)), SUM_W'({$urandom, $urandom}), CNT_W'($urandom_range(7)));
    sweep("rand30", 30, 0, -1, -1);

    clear_all();
    load(50, 38'd1, 3'd1);
    load(4000, 38'd3, 3'd3);
    sweep("midstart", 100, 0, 50, -1);

    clear_all();
    load(10, 38'd77, 3'd1);
    load(4000, 38'd123, 3'd4);
    sweep("abort", 100, 0, -1, 200);
    want_sum[10] = '0;
    want_cnt[10] = '0;
    @(negedge clk);
    sweep("resweep", 100, 0, -1, -1);
    chk("resweep_totalSum", totalSum, 64'd123);

    clear_all();
    load(100, {SUM_W{1'b1}}, 3'd6);
    load(4095, {SUM_W{1'b1}}, 3'd6);
    sweep("maxval", 100, 0, -1, -1);
    chk("maxval_totalSum", totalSum, 64'h0000_007F_FFFF_FFFE);
    chk("maxval_totalCount", 64'(totalCount), 64'd12);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
